// File: rtl/logistic_regression_hls_deadlock_pkg.sv
// Shared types and constants for the HLS deadlock report controller.
package logistic_regression_hls_deadlock_pkg;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } rpt_state_e;

  localparam int TS_W_DEFAULT = 32;
  localparam int ID_W_DEFAULT = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/logistic_regression_hls_deadlock_report_ctrl_if.sv
// Valid/ready report channel carrying confirmed deadlock records.
interface logistic_regression_hls_deadlock_report_ctrl_if #(
  parameter int ID_W = 4,
  parameter int TS_W = 32
) ();
  logic            rpt_valid;
  logic            rpt_ready;
  logic [ID_W-1:0] rpt_id;
  logic [TS_W-1:0] rpt_ts;

  modport master (output rpt_valid, output rpt_id, output rpt_ts, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_id, input rpt_ts, output rpt_ready);
endinterface

// File: rtl/logistic_regression_hls_deadlock_persist_cnt.sv
// One monitor: saturating persistence counter, sticky confirm flag and
// timestamp capture at the moment of confirmation.
module logistic_regression_hls_deadlock_persist_cnt #(
  parameter int PERSIST = 16,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            clear,
  input  logic            block,
  input  logic [TS_W-1:0] ts_now,
  output logic            fire,
  output logic            confirmed,
  output logic [TS_W-1:0] ts_cap
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == CNT_MAX);
  // Fires on the PERSIST-th consecutive block cycle, once per clear epoch.
  assign fire   = enable & ~clear & block & at_max & ~confirmed;

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the captured timestamp, has a defined async reset value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      confirmed <= 1'b0;
      ts_cap    <= '0;
    end else begin
      if (clear || !enable || !block) cnt <= '0;
      else if (!at_max)               cnt <= cnt + 1'b1;

      if (clear)     confirmed <= 1'b0;
      else if (fire) confirmed <= 1'b1;

      if (fire) ts_cap <= ts_now;
    end
  end

endmodule

// File: rtl/logistic_regression_hls_deadlock_report_ctrl.sv
// Filters monitor block signals, latches confirmed deadlocks and serializes
// one report per confirmation onto a valid/ready channel (round-robin).
module logistic_regression_hls_deadlock_report_ctrl
  import logistic_regression_hls_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int PERSIST = 16,
  parameter int CNT_W   = 8,
  parameter int TS_W    = TS_W_DEFAULT,
  parameter int ID_W    = ID_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               deadlock,
  output logic [NUM_MON-1:0] deadlock_vec,
  output logic [TS_W-1:0]    ts_now,
  logistic_regression_hls_deadlock_report_ctrl_if.master rpt
);
  localparam int PTR_W = (NUM_MON > 1) ? clog2(NUM_MON) : 1;

  rpt_state_e         state, state_n;
  logic [NUM_MON-1:0] pend, pend_n, fire;
  logic [PTR_W-1:0]   ptr, ptr_n, sel, sel_n, pick;
  logic               pick_found;
  logic               valid_n;
  logic [ID_W-1:0]    id_n;
  logic [TS_W-1:0]    rts_n;
  logic [TS_W-1:0]    ts_cap [NUM_MON];
  logic [PTR_W-1:0]   rr_idx [NUM_MON];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    ts_now <= '0;
    else if (enable) ts_now <= ts_now + 1'b1;
  end

  for (genvar i = 0; i < NUM_MON; i++) begin : g_mon
    logistic_regression_hls_deadlock_persist_cnt #(
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W),
      .TS_W    (TS_W)
    ) u_persist (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable),
      .clear     (clear),
      .block     (mon_block[i]),
      .ts_now    (ts_now),
      .fire      (fire[i]),
      .confirmed (deadlock_vec[i]),
      .ts_cap    (ts_cap[i])
    );
    // Candidate order for the round-robin search, starting at ptr.
    assign rr_idx[i] = PTR_W'((int'(ptr) + i) % NUM_MON);
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    // Walk from the far end so the nearest pending index after ptr wins.
    for (int k = NUM_MON - 1; k >= 0; k--) begin
      if (pend[rr_idx[k]]) begin
        pick_found = 1'b1;
        pick       = rr_idx[k];
      end
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend | fire;
    ptr_n   = ptr;
    sel_n   = sel;
    valid_n = rpt.rpt_valid;
    id_n    = rpt.rpt_id;
    rts_n   = rpt.rpt_ts;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_n = S_PRESENT;
          sel_n   = pick;
          valid_n = 1'b1;
          id_n    = ID_W'(pick);
          rts_n   = ts_cap[pick];
        end
      end
      S_PRESENT: begin
        if (rpt.rpt_ready) begin
          state_n     = S_IDLE;
          pend_n[sel] = 1'b0;
          ptr_n       = (sel == PTR_W'(NUM_MON - 1)) ? '0 : sel + 1'b1;
          valid_n     = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Clear drops pending work and withdraws any presented record; ptr survives.
    if (clear) begin
      state_n = S_IDLE;
      pend_n  = '0;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pend          <= '0;
      ptr           <= '0;
      sel           <= '0;
      deadlock      <= 1'b0;
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_id    <= '0;
      rpt.rpt_ts    <= '0;
    end else begin
      state         <= state_n;
      pend          <= pend_n;
      ptr           <= ptr_n;
      sel           <= sel_n;
      deadlock      <= ~clear & (|(deadlock_vec | fire));
      rpt.rpt_valid <= valid_n;
      rpt.rpt_id    <= id_n;
      rpt.rpt_ts    <= rts_n;
    end
  end

endmodule

// File: tb/tb_logistic_regression_hls_deadlock_report_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a cycle-level behavioural model.
module tb_logistic_regression_hls_deadlock_report_ctrl;
  localparam int NUM_MON = 4;
  localparam int PERSIST = 16;
  localparam int CNT_W   = 8;
  localparam int TS_W    = 32;
  localparam int ID_W    = 4;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               enable = 1'b0;
  logic               clear = 1'b0;
  logic [NUM_MON-1:0] mon_block = '0;
  logic               rpt_ready = 1'b0;
  logic               deadlock;
  logic [NUM_MON-1:0] deadlock_vec;
  logic [TS_W-1:0]    ts_now;

  logistic_regression_hls_deadlock_report_ctrl_if #(.ID_W(ID_W), .TS_W(TS_W)) rpt ();
  assign rpt.rpt_ready = rpt_ready;

  logistic_regression_hls_deadlock_report_ctrl #(
    .NUM_MON (NUM_MON),
    .PERSIST (PERSIST),
    .CNT_W   (CNT_W),
    .TS_W    (TS_W),
    .ID_W    (ID_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear        (clear),
    .mon_block    (mon_block),
    .deadlock     (deadlock),
    .deadlock_vec (deadlock_vec),
    .ts_now       (ts_now),
    .rpt          (rpt.master)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run lengths of consecutive block cycles, a set of
  // pending reports and at most one record on offer.
  int                 m_run [NUM_MON];
  logic [NUM_MON-1:0] m_vec, m_pend;
  logic [TS_W-1:0]    m_ts, m_rts;
  logic [TS_W-1:0]    m_cap [NUM_MON];
  logic               m_valid;
  int                 m_id, m_ptr;

  task automatic model_reset();
    for (int i = 0; i < NUM_MON; i++) begin
      m_run[i] = 0;
      m_cap[i] = '0;
    end
    m_vec = '0; m_pend = '0; m_ts = '0; m_rts = '0;
    m_valid = 1'b0; m_id = 0; m_ptr = 0;
  endtask

  task automatic model_edge();
    if (clear) begin
      m_vec = '0; m_pend = '0; m_valid = 1'b0;
      for (int i = 0; i < NUM_MON; i++) m_run[i] = 0;
    end else begin
      if (m_valid) begin
        if (rpt_ready) begin
          m_pend[m_id] = 1'b0;
          m_ptr = (m_id + 1) % NUM_MON;
          m_valid = 1'b0;
        end
      end else if (m_pend != '0) begin
        for (int k = 0; k < NUM_MON; k++) begin
          if (!m_valid && m_pend[(m_ptr + k) % NUM_MON]) begin
            m_valid = 1'b1;
            m_id = (m_ptr + k) % NUM_MON;
            m_rts = m_cap[m_id];
          end
        end
      end
      for (int i = 0; i < NUM_MON; i++) begin
        if (enable && mon_block[i]) begin
          m_run[i]++;
          if (m_run[i] >= PERSIST && !m_vec[i]) begin
            m_vec[i] = 1'b1;
            m_pend[i] = 1'b1;
            m_cap[i] = m_ts;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (enable) m_ts = m_ts + 1;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    check("rand_deadlock", 64'(deadlock), 64'(|m_vec));
    check("rand_vec", 64'(deadlock_vec), 64'(m_vec));
    check("rand_valid", 64'(rpt.rpt_valid), 64'(m_valid));
    check("rand_ts_now", 64'(ts_now), 64'(m_ts));
    if (m_valid) begin
      check("rand_id", 64'(rpt.rpt_id), 64'(m_id));
      check("rand_rpt_ts", 64'(rpt.rpt_ts), 64'(m_rts));
    end
  endtask

  typedef struct {
    logic [NUM_MON-1:0] blk;
    logic               en;
    logic               clr;
    logic               rdy;
    int                 n;
    logic               dl;
    logic [NUM_MON-1:0] vec;
    logic               val;
    logic [ID_W-1:0]    id;
    logic [TS_W-1:0]    rts;
    logic [TS_W-1:0]    tsn;
  } vec_t;

  function automatic vec_t mk(input logic [NUM_MON-1:0] blk, input logic en, input logic clr,
                              input logic rdy, input int n, input logic dl,
                              input logic [NUM_MON-1:0] vec, input logic val,
                              input logic [ID_W-1:0] id, input logic [TS_W-1:0] rts,
                              input logic [TS_W-1:0] tsn);
    vec_t v;
    v.blk = blk; v.en = en; v.clr = clr; v.rdy = rdy; v.n = n;
    v.dl = dl; v.vec = vec; v.val = val; v.id = id; v.rts = rts; v.tsn = tsn;
    return v;
  endfunction

  vec_t tbl[$];
  logic [TS_W-1:0] conf_ts, frozen;

  initial begin
    // Simultaneous confirmation of 0 and 3, drained round-robin from ptr=0.
    tbl.push_back(mk(4'b1001, 1, 0, 1, 16, 1, 4'b1001, 0, 0,   0,  16));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1001, 1, 0,  15,  17));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1001, 0, 0,   0,  18));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1001, 1, 3,  15,  19));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1001, 0, 0,   0,  20));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1001, 0, 0,   0,  21));
    tbl.push_back(mk(4'b0010, 1, 0, 1, 16, 1, 4'b1011, 0, 0,   0,  37));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1011, 1, 1,  36,  38));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b1011, 0, 0,   0,  39));
    tbl.push_back(mk(4'b0000, 1, 1, 1,  1, 0, 4'b0000, 0, 0,   0,  40));
    // 15 block cycles do not confirm; 16 starting at ts_now=100 do.
    tbl.push_back(mk(4'b0000, 1, 0, 1, 40, 0, 4'b0000, 0, 0,   0,  80));
    tbl.push_back(mk(4'b0100, 1, 0, 1, 15, 0, 4'b0000, 0, 0,   0,  95));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  5, 0, 4'b0000, 0, 0,   0, 100));
    tbl.push_back(mk(4'b0100, 1, 0, 1, 15, 0, 4'b0000, 0, 0,   0, 115));
    tbl.push_back(mk(4'b0100, 1, 0, 1,  1, 1, 4'b0100, 0, 0,   0, 116));
    tbl.push_back(mk(4'b0000, 1, 0, 0,  1, 1, 4'b0100, 1, 2, 115, 117));
    tbl.push_back(mk(4'b0000, 1, 0, 1,  1, 1, 4'b0100, 0, 0,   0, 118));

    model_reset();
    #1 reset_n = 1'b0;
    #12;
    check("reset_deadlock", 64'(deadlock), 64'(0));
    check("reset_vec", 64'(deadlock_vec), 64'(0));
    check("reset_valid", 64'(rpt.rpt_valid), 64'(0));
    check("reset_ts_now", 64'(ts_now), 64'(0));
    check("reset_id", 64'(rpt.rpt_id), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;

    foreach (tbl[r]) begin
      mon_block = tbl[r].blk; enable = tbl[r].en; clear = tbl[r].clr; rpt_ready = tbl[r].rdy;
      repeat (tbl[r].n) step();
      clear = 1'b0;
      check($sformatf("tbl%0d_deadlock", r), 64'(deadlock), 64'(tbl[r].dl));
      check($sformatf("tbl%0d_vec", r), 64'(deadlock_vec), 64'(tbl[r].vec));
      check($sformatf("tbl%0d_valid", r), 64'(rpt.rpt_valid), 64'(tbl[r].val));
      check($sformatf("tbl%0d_ts_now", r), 64'(ts_now), 64'(tbl[r].tsn));
      if (tbl[r].val) begin
        check($sformatf("tbl%0d_id", r), 64'(rpt.rpt_id), 64'(tbl[r].id));
        check($sformatf("tbl%0d_rpt_ts", r), 64'(rpt.rpt_ts), 64'(tbl[r].rts));
      end
    end

    // Backpressure: record held stable for 20 cycles while monitor 1 confirms.
    mon_block = 4'b0001; rpt_ready = 1'b0;
    repeat (16) step();
    mon_block = 4'b0000;
    step();
    check("bp_valid", 64'(rpt.rpt_valid), 64'(1));
    check("bp_id", 64'(rpt.rpt_id), 64'(0));
    check("bp_rpt_ts", 64'(rpt.rpt_ts), 64'(133));
    conf_ts = '0;
    for (int w = 0; w < 20; w++) begin
      if (w == 2) begin
        mon_block = 4'b0010;
        conf_ts = m_ts + TS_W'(PERSIST - 1);
      end
      if (w == 18) mon_block = 4'b0000;
      step();
      check("bp_hold_valid", 64'(rpt.rpt_valid), 64'(1));
      check("bp_hold_id", 64'(rpt.rpt_id), 64'(0));
      check("bp_hold_ts", 64'(rpt.rpt_ts), 64'(133));
    end
    check("bp_vec", 64'(deadlock_vec), 64'(4'b0111));
    rpt_ready = 1'b1;
    step();
    check("bp_accept_valid", 64'(rpt.rpt_valid), 64'(0));
    step();
    check("bp_next_valid", 64'(rpt.rpt_valid), 64'(1));
    check("bp_next_id", 64'(rpt.rpt_id), 64'(1));
    check("bp_next_ts", 64'(rpt.rpt_ts), 64'(conf_ts));
    step();
    check("bp_drained", 64'(rpt.rpt_valid), 64'(0));

    // Clear while a record is presented and two monitors are pending.
    clear = 1'b1; step(); clear = 1'b0;
    check("clr0_vec", 64'(deadlock_vec), 64'(0));
    mon_block = 4'b0011;
    repeat (16) step();
    mon_block = 4'b0000; rpt_ready = 1'b0;
    step();
    check("clr_pre_valid", 64'(rpt.rpt_valid), 64'(1));
    check("clr_pre_id", 64'(rpt.rpt_id), 64'(0));
    check("clr_pre_vec", 64'(deadlock_vec), 64'(4'b0011));
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_valid", 64'(rpt.rpt_valid), 64'(0));
    check("clr_deadlock", 64'(deadlock), 64'(0));
    check("clr_vec", 64'(deadlock_vec), 64'(0));
    rpt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("clr_no_record", 64'(rpt.rpt_valid), 64'(0));
    end

    // Disable mid-count: timestamp frozen and the count starts over.
    mon_block = 4'b0100;
    repeat (8) step();
    enable = 1'b0;
    frozen = ts_now;
    for (int c = 0; c < 10; c++) begin
      step();
      check("dis_ts_frozen", 64'(ts_now), 64'(frozen));
    end
    enable = 1'b1;
    repeat (15) step();
    check("dis_no_confirm", 64'(deadlock_vec), 64'(0));
    step();
    check("dis_confirm", 64'(deadlock_vec), 64'(4'b0100));
    check("dis_deadlock", 64'(deadlock), 64'(1));
    mon_block = 4'b0000; rpt_ready = 1'b0;
    step();
    check("dis_valid", 64'(rpt.rpt_valid), 64'(1));
    check("dis_id", 64'(rpt.rpt_id), 64'(2));

    // Asynchronous reset while presenting, away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("areset_valid", 64'(rpt.rpt_valid), 64'(0));
    check("areset_deadlock", 64'(deadlock), 64'(0));
    check("areset_vec", 64'(deadlock_vec), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    check("areset_ts0", 64'(ts_now), 64'(0));
    step();
    check("areset_ts1", 64'(ts_now), 64'(1));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (mon_block[i]) begin
          if ($urandom_range(39) == 0) mon_block[i] = 1'b0;
        end else if ($urandom_range(9) == 0) begin
          mon_block[i] = 1'b1;
        end
      end
      enable    = ($urandom_range(19) != 0);
      clear     = ($urandom_range(299) == 0);
      rpt_ready = ($urandom_range(2) != 0);
      step();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logistic_regression_hls_deadlock_report_ctrl.md
Name: logistic_regression_hls_deadlock_report_ctrl

Overview:
Collects the per-dataflow-region `block` outputs of the HLS deadlock monitors and filters transient stalls with a per-monitor persistence counter. Confirmed deadlocks are latched into a sticky status, each with a timestamp. Confirmed events are serialized onto a valid/ready report channel, using round-robin arbitration among pending monitors. Sits at top level beside the logistic_regression dataflow instance and feeds the debug/status register block.

Parameters:
NUM_MON, 4, number of monitor `block` inputs (1..16)
PERSIST, 16, consecutive block cycles needed to confirm a deadlock (2..2^CNT_W-1)
CNT_W, 8, persistence counter width
TS_W, 32, timestamp counter width
ID_W, 4, report id width (>= clog2(NUM_MON))

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = watch monitors; 0 = counters and timestamp held, pending kept
clear  in  1  single-cycle pulse: drop all pending/sticky state and any presented report
mon_block  in  NUM_MON  block output of each deadlock monitor
deadlock  out  1  sticky: any monitor confirmed since last clear
deadlock_vec  out  NUM_MON  sticky per-monitor confirmed flags
rpt_valid  out  1  report record available
rpt_ready  in  1  consumer accepts record
rpt_id  out  ID_W  index of reporting monitor
rpt_ts  out  TS_W  timestamp at confirmation
ts_now  out  TS_W  free-running timestamp

Behaviour:
- Reset (async assert, sync deassert external): all outputs 0, all counters 0, FSM = S_IDLE, round-robin pointer = 0.
- Timestamp: increments by 1 every cycle enable=1 and wraps 2^TS_W-1 -> 0 silently. Held while enable=0; cleared only by reset.
- Persistence, per monitor i, with enable=1:
  - mon_block[i]=0 -> cnt[i]<=0.
  - mon_block[i]=1 and cnt[i]<PERSIST-1 -> cnt[i]++.
  - When cnt[i]==PERSIST-1 and mon_block[i]=1 and deadlock_vec[i]=0 -> set deadlock_vec[i], pend[i], capture ts[i]<=ts_now.
  - Confirmation therefore occurs on the PERSIST-th consecutive block cycle and is visible one cycle later.
  - cnt[i] saturates at PERSIST-1. An already-confirmed monitor never re-confirms until clear.
- enable=0: all cnt[i]<=0; no new confirmations. Pending reports still drain.
- deadlock = |deadlock_vec, registered with it.
- FSM:
  - S_IDLE: if |pend -> pick lowest index j >= ptr (wrap to 0) with pend[j]; load rpt_id=j, rpt_ts=ts[j]; rpt_valid<=1; go S_PRESENT.
  - S_PRESENT: rpt_valid, rpt_id, rpt_ts held stable until rpt_ready=1. On handshake: pend[j]<=0, ptr<=j+1 (mod NUM_MON), rpt_valid<=0, go S_IDLE.
  - Minimum report spacing is therefore 2 cycles (one bubble).
- Simultaneous confirmation of several monitors in one cycle: all pend set; drained in round-robin order, one record each.
- Confirmation of monitor k while S_PRESENT on j: pend[k] set; the presented record is unaffected.
- clear, which has priority over everything except reset:
  - deadlock_vec, pend, cnt and rpt_valid go to 0 next cycle; FSM -> S_IDLE; ptr unchanged.
  - A record presented when clear asserts is dropped even without ready. This is the only permitted valid withdrawal.
  - Confirmation in the same cycle as clear is lost; cnt restarts from 0.
- Widths: rpt_id is zero-extended from clog2(NUM_MON). Unused upper mon indices do not exist (no masking needed).

Decomposition:
- Shared package logistic_regression_hls_deadlock_pkg: FSM state enum (S_IDLE, S_PRESENT), a clog2 function, default TS_W/ID_W constants.
- One natural sub-module: logistic_regression_hls_deadlock_persist_cnt. It is a single-monitor saturating counter plus confirm/sticky logic, instantiated NUM_MON times via generate.
- Round-robin pick stays inline.

Test Plan:
1. PERSIST=16, mon_block[2]=1 for 15 cycles then 0 -> no deadlock; repeat for 16 cycles from ts_now=100 -> deadlock=1, deadlock_vec=4'b0100 one cycle after the 16th. rpt_id=2, rpt_ts=115.
2. mon_block[0] and [3] confirm in the same cycle, rpt_ready=1 -> records id 0 then id 3, 2 cycles apart. Then confirm [1] with ptr=0 after draining -> id 1.
3. rpt_ready=0 for 20 cycles with record pending -> rpt_valid, rpt_id, rpt_ts stable throughout. A new confirmation in that window is reported after the handshake.
4. clear pulsed while rpt_valid=1 and two pend bits set -> next cycle rpt_valid=0, deadlock=0, deadlock_vec=0. No further records.
5. enable=0 for 10 cycles mid-count (cnt=8) -> ts_now frozen; cnt back to 0. After re-enable, 16 fresh block cycles are required to confirm.
6. Assert reset_n=0 asynchronously mid S_PRESENT (no clock edge) -> rpt_valid and deadlock drop immediately. After release, ts_now restarts at 0.
